// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants and types.
// Imported by the register file and its pending-writer counters.
package arm_pkg;

    localparam int ARM_DATA_W   = 32;
    localparam int ARM_NUM_REGS = 16;
    localparam int ARM_PC_IDX   = 15;

    typedef logic [$clog2(ARM_NUM_REGS)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_pend_counter.sv
// Pending-writer counter for one register.
// Adds one per accepted issue, subtracts one per write-back, clamps at zero.
module pend_counter
    import arm_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [1:0]        dec,
    output logic [PEND_W-1:0] count,
    output logic              at_max,
    output logic              underflow
);

    logic [PEND_W:0]   up;
    logic [PEND_W-1:0] next;

    // Saturation is prevented upstream: inc at max only with dec >= 1.
    always_comb begin
        up        = {1'b0, count} + (PEND_W + 1)'(inc);
        underflow = (PEND_W + 1)'(dec) > up;
        next      = '0;
        if (!underflow) begin
            next = PEND_W'(up - (PEND_W + 1)'(dec));
        end
    end

    assign at_max = &count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write-back ports, read bypass and
// per-register pending-writer scoreboard.
module regfile_sb
    import arm_pkg::*;
#(
    parameter int DATA_W     = ARM_DATA_W,
    parameter int NUM_REGS   = ARM_NUM_REGS,
    parameter int ADDR_W     = $clog2(NUM_REGS),
    parameter int NUM_RD     = 2,
    parameter int PEND_W     = 2,
    parameter int INIT_INDEX = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     wb0_en,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_en,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    output logic                     err_underflow
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [PEND_W-1:0] cnt  [NUM_REGS];
    logic [1:0]        dec  [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] at_max;
    logic [NUM_REGS-1:0] uflow;
    logic [NUM_REGS-1:0] busy;
    logic wb0_iss;
    logic wb1_iss;
    logic iss_acc;

    // A write-back to the issue target frees a slot in the same cycle.
    assign wb0_iss   = wb0_en && (wb0_addr == iss_addr);
    assign wb1_iss   = wb1_en && (wb1_addr == iss_addr);
    assign iss_ready = rst || !at_max[iss_addr] || wb0_iss || wb1_iss;
    assign iss_acc   = iss_en && iss_ready;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic hit0;
        logic hit1;

        assign hit0    = wb0_en && (wb0_addr == ADDR_W'(r));
        assign hit1    = wb1_en && (wb1_addr == ADDR_W'(r));
        assign dec[r]  = {1'b0, hit0} + {1'b0, hit1};
        assign inc[r]  = iss_acc && (iss_addr == ADDR_W'(r));
        assign busy[r] = (PEND_W + 2)'(cnt[r]) > (PEND_W + 2)'(dec[r]);

        pend_counter #(
            .PEND_W(PEND_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[r]),
            .dec      (dec[r]),
            .count    (cnt[r]),
            .at_max   (at_max[r]),
            .underflow(uflow[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;

        assign a = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_data[i*DATA_W +: DATA_W] =
            (wb1_en && wb1_addr == a) ? wb1_data :
            (wb0_en && wb0_addr == a) ? wb0_data :
            regs[a];
        assign rd_busy[i] = busy[a] && !rst;
    end

    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            if (wb0_en) begin
                regs[wb0_addr] <= wb0_data;
            end
            if (wb1_en) begin
                regs[wb1_addr] <= wb1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (|uflow) begin
            err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_regfile_sb;

    localparam int DW   = 32;
    localparam int NR   = 16;
    localparam int AW   = 4;
    localparam int NRD  = 2;
    localparam int MAXC = 3;

    logic clk = 1'b0;
    logic rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              iss_ready;
    logic              wb0_en;
    logic [AW-1:0]     wb0_addr;
    logic [DW-1:0]     wb0_data;
    logic              wb1_en;
    logic [AW-1:0]     wb1_addr;
    logic [DW-1:0]     wb1_data;
    logic              err_underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_reg [NR];
    int            m_cnt [NR];
    bit            m_err;

    regfile_sb dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .iss_en       (iss_en),
        .iss_addr     (iss_addr),
        .iss_ready    (iss_ready),
        .wb0_en       (wb0_en),
        .wb0_addr     (wb0_addr),
        .wb0_data     (wb0_data),
        .wb1_en       (wb1_en),
        .wb1_addr     (wb1_addr),
        .wb1_data     (wb1_data),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic int wb_hits(int r);
        int n = 0;
        if (wb0_en && int'(wb0_addr) == r) n++;
        if (wb1_en && int'(wb1_addr) == r) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(int a);
        if (wb1_en && int'(wb1_addr) == a) return wb1_data;
        if (wb0_en && int'(wb0_addr) == a) return wb0_data;
        return m_reg[a];
    endfunction

    function automatic bit exp_busy(int a);
        if (rst) return 1'b0;
        return (m_cnt[a] - wb_hits(a)) > 0;
    endfunction

    function automatic bit exp_ready();
        if (rst) return 1'b1;
        return (m_cnt[iss_addr] < MAXC) || (wb_hits(iss_addr) > 0);
    endfunction

    function automatic logic [DW-1:0] rd(int p);
        return rd_data[p*DW +: DW];
    endfunction

    task automatic set_rd(int p, int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic idle();
        iss_en   = 1'b0;
        iss_addr = '0;
        wb0_en   = 1'b0;
        wb0_addr = '0;
        wb0_data = '0;
        wb1_en   = 1'b0;
        wb1_addr = '0;
        wb1_data = '0;
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic tick();
        bit acc;
        int n;
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                m_reg[i] = DW'(i);
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
        end else begin
            acc = iss_en && exp_ready();
            for (int r = 0; r < NR; r++) begin
                n = m_cnt[r] - wb_hits(r);
                if (acc && int'(iss_addr) == r) n++;
                if (n < 0) begin
                    n = 0;
                    m_err = 1'b1;
                end
                m_cnt[r] = n;
            end
            if (wb0_en) m_reg[wb0_addr] = wb0_data;
            if (wb1_en) m_reg[wb1_addr] = wb1_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        set_rd(0, 3);
        set_rd(1, 15);
        #1;
        checks++;
        if (iss_ready !== 1'b1 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_during: ready %b busy %b want 1 00",
                     iss_ready, rd_busy);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (rd(0) !== 32'd3) begin
            errors++;
            $display("FAIL reset_r3: got %h want 3", rd(0));
        end
        checks++;
        if (rd(1) !== 32'd15) begin
            errors++;
            $display("FAIL reset_r15: got %h want f", rd(1));
        end
        checks++;
        if (rd_busy !== 2'b00 || iss_ready !== 1'b1 ||
            err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy %b ready %b err %b",
                     rd_busy, iss_ready, err_underflow);
        end
    endtask

    task automatic test_write_bypass();
        idle();
        iss_en   = 1'b1;
        iss_addr = 4'd4;
        tick();
        idle();
        wb1_en   = 1'b1;
        wb1_addr = 4'd4;
        wb1_data = 32'hDEADBEEF;
        set_rd(0, 4);
        #1;
        checks++;
        if (rd(0) !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_r4: got %h busy %b want deadbeef 0",
                     rd(0), rd_busy[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd(0) !== 32'hDEADBEEF || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL stored_r4: got %h err %b want deadbeef 0",
                     rd(0), err_underflow);
        end
    endtask

    task automatic test_dual_write();
        idle();
        set_rd(0, 2);
        iss_en   = 1'b1;
        iss_addr = 4'd2;
        tick();
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL dual_pend: busy %b want 1", rd_busy[0]);
        end
        wb0_en   = 1'b1;
        wb0_addr = 4'd2;
        wb0_data = 32'h11;
        wb1_en   = 1'b1;
        wb1_addr = 4'd2;
        wb1_data = 32'h22;
        #1;
        checks++;
        if (rd(0) !== 32'h22 || rd_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL dual_same: got %h busy %b want 22 0",
                     rd(0), rd_busy[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd(0) !== 32'h22 || rd_busy[0] !== 1'b0 ||
            err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL dual_after: got %h busy %b err %b want 22 0 0",
                     rd(0), rd_busy[0], err_underflow);
        end
    endtask

    task automatic test_saturation();
        idle();
        set_rd(0, 5);
        iss_en   = 1'b1;
        iss_addr = 4'd5;
        repeat (MAXC) tick();
        checks++;
        if (rd_busy[0] !== 1'b1 || iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_full: busy %b ready %b want 1 0",
                     rd_busy[0], iss_ready);
        end
        tick();
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: ready %b want 0", iss_ready);
        end
        wb0_en   = 1'b1;
        wb0_addr = 4'd5;
        wb0_data = 32'h55;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_wb_ready: ready %b want 1", iss_ready);
        end
        tick();
        wb0_en = 1'b0;
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            errors++;
            $display("FAIL sat_stays_max: ready %b want 0", iss_ready);
        end
        iss_en = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            wb1_en   = 1'b1;
            wb1_addr = 4'd5;
            wb1_data = DW'(k);
            #1;
            checks++;
            if (rd_busy[0] !== (k < MAXC - 1)) begin
                errors++;
                $display("FAIL sat_drain%0d: busy %b want %b",
                         k, rd_busy[0], (k < MAXC - 1));
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || err_underflow !== 1'b0) begin
            errors++;
            $display("FAIL sat_empty: busy %b err %b want 0 0",
                     rd_busy[0], err_underflow);
        end
    endtask

    task automatic test_underflow();
        idle();
        set_rd(1, 7);
        iss_en   = 1'b1;
        iss_addr = 4'd7;
        tick();
        idle();
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL uf_pend: busy %b want 1", rd_busy[1]);
        end
        wb1_en   = 1'b1;
        wb1_addr = 4'd7;
        wb1_data = 32'h77;
        #1;
        checks++;
        if (rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL uf_clear: busy %b want 0", rd_busy[1]);
        end
        tick();
        idle();
        wb0_en   = 1'b1;
        wb0_addr = 4'd7;
        wb0_data = 32'h78;
        tick();
        idle();
        #1;
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_set: err %b want 1", err_underflow);
        end
        repeat (3) tick();
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_sticky: err %b want 1", err_underflow);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        iss_en   = 1'b1;
        iss_addr = 4'd9;
        tick();
        iss_addr = 4'd10;
        tick();
        rst      = 1'b1;
        iss_addr = 4'd9;
        wb0_en   = 1'b1;
        wb0_addr = 4'd9;
        wb0_data = 32'hCAFE;
        tick();
        rst = 1'b0;
        idle();
        #1;
        checks++;
        if (err_underflow !== 1'b0 || iss_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_flags: err %b ready %b want 0 1",
                     err_underflow, iss_ready);
        end
        for (int i = 0; i < NR; i++) begin
            set_rd(0, i);
            #1;
            checks++;
            if (rd(0) !== DW'(i) || rd_busy[0] !== 1'b0) begin
                errors++;
                $display("FAIL mid_r%0d: got %h busy %b want %h 0",
                         i, rd(0), rd_busy[0], DW'(i));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 63) == 0);
            iss_en   = $urandom_range(0, 1) == 1;
            iss_addr = AW'($urandom_range(0, 7));
            wb0_en   = $urandom_range(0, 2) == 0;
            wb0_addr = AW'($urandom_range(0, 7));
            wb0_data = $urandom;
            wb1_en   = $urandom_range(0, 2) == 0;
            wb1_addr = AW'($urandom_range(0, 7));
            wb1_data = $urandom;
            set_rd(0, $urandom_range(0, 7));
            set_rd(1, $urandom_range(0, NR - 1));
            #1;
            for (int p = 0; p < NRD; p++) begin
                checks++;
                if (rd(p) !== exp_data(rd_addr[p*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand_data c%0d p%0d: got %h want %h",
                             c, p, rd(p), exp_data(rd_addr[p*AW +: AW]));
                end
                checks++;
                if (rd_busy[p] !== exp_busy(rd_addr[p*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand_busy c%0d p%0d: got %b want %b",
                             c, p, rd_busy[p],
                             exp_busy(rd_addr[p*AW +: AW]));
                end
            end
            checks++;
            if (iss_ready !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready c%0d: got %b want %b",
                         c, iss_ready, exp_ready());
            end
            checks++;
            if (err_underflow !== m_err) begin
                errors++;
                $display("FAIL rand_err c%0d: got %b want %b",
                         c, err_underflow, m_err);
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        idle();
        test_reset();
        test_write_bypass();
        test_dual_write();
        test_saturation();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
